// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter.
//   arb_state_e   - arbiter FSM states (idle, port 0 granted, port 1 granted)
//   PORT0/PORT1   - port index constants used for the last-served pointer
//   Grant*        - one-hot grant status encodings
//   grant_onehot  - maps a port index to its one-hot grant value
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] Grant0    = 2'b01;
    localparam logic [1:0] Grant1    = 2'b10;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return (idx == PORT1) ? Grant1 : Grant0;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner selection for the SRAM arbiter.
// Build option: SRAM_ARB_RR_EN selects round-robin on ties; otherwise port 0
// always wins (fixed priority) and last_served is ignored.
// Ports:
//   req[1:0]     - request bits, req[0] = port 0, req[1] = port 1
//   last_served  - index of the port served most recently
//   winner       - index of the selected port (don't-care when valid = 0)
//   valid        - at least one port is requesting
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       winner,
    output logic       valid
);

    assign valid = |req;

`ifdef SRAM_ARB_RR_EN
    // On a tie the port that was not served last goes next; a lone requester
    // always wins.
    always_comb begin
        winner = PORT0;
        if (req[0] && req[1]) begin
            winner = ~last_served;
        end else if (req[1]) begin
            winner = PORT1;
        end
    end
`else
    always_comb begin
        winner = req[0] ? PORT0 : PORT1;
    end

    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller command port between two
// requesters (port 0: data access, port 1: fetch / secondary master).
// Build option: SRAM_ARB_RR_EN enables round-robin tie breaking
// (default: fixed priority, port 0 wins).
// Ports:
//   clk, rst                     - clock (rising edge), async active-high reset
//   pX_wr_en / pX_rd_en          - port X request, held until pX_ready
//   pX_address / pX_write_data   - port X command address and write data
//   pX_read_data                 - read data, valid while pX_ready = 1
//   pX_ready                     - port X completion pulse
//   pX_busy                      - pipeline freeze: request pending, not ready
//   mem_wr_en / mem_rd_en        - registered command enables to the controller
//   mem_address / mem_write_data - registered command address and data
//   mem_read_data / mem_ready    - controller read data and completion pulse
//   grant                        - one-hot owner status (bit0 port 0, bit1 port 1)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_wr_en,
    input  logic              p0_rd_en,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_write_data,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_ready,
    output logic              p0_busy,

    input  logic              p1_wr_en,
    input  logic              p1_rd_en,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_write_data,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_ready,
    output logic              p1_busy,

    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,

    output logic [1:0]        grant
);

    arb_state_e        state_q;
    logic              mem_wr_en_q;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_write_data_q;
    logic [1:0]        grant_q;
    logic              last_served_q;

    logic [1:0]        req;
    logic              pick_winner;
    logic              pick_valid;

    logic              sel_wr;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_write_data;

    assign req = {p1_wr_en | p1_rd_en, p0_wr_en | p0_rd_en};

    sram_arb_pick u_pick (
        .req         (req),
        .last_served (last_served_q),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

    always_comb begin
        if (pick_winner == PORT1) begin
            sel_wr         = p1_wr_en;
            sel_rd         = p1_rd_en;
            sel_address    = p1_address;
            sel_write_data = p1_write_data;
        end else begin
            sel_wr         = p0_wr_en;
            sel_rd         = p0_rd_en;
            sel_address    = p0_address;
            sel_write_data = p0_write_data;
        end
    end

    // Command registers only load in idle, so the controller sees a stable
    // command for the whole access. Leaving a grant always passes through
    // idle, which forces at least one cycle with both enables low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            mem_wr_en_q      <= 1'b0;
            mem_rd_en_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            grant_q          <= GrantNone;
            last_served_q    <= PORT1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q          <= (pick_winner == PORT1) ? StGnt1 : StGnt0;
                        mem_wr_en_q      <= sel_wr;
                        // A simultaneous write and read is treated as a write.
                        mem_rd_en_q      <= sel_rd & ~sel_wr;
                        mem_address_q    <= sel_address;
                        mem_write_data_q <= sel_write_data;
                        grant_q          <= grant_onehot(pick_winner);
                    end
                end
                StGnt0, StGnt1: begin
                    if (mem_ready) begin
                        state_q       <= StIdle;
                        mem_wr_en_q   <= 1'b0;
                        mem_rd_en_q   <= 1'b0;
                        grant_q       <= GrantNone;
                        last_served_q <= (state_q == StGnt1) ? PORT1 : PORT0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mem_wr_en_q <= 1'b0;
                    mem_rd_en_q <= 1'b0;
                    grant_q     <= GrantNone;
                end
            endcase
        end
    end

    assign mem_wr_en      = mem_wr_en_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign grant          = grant_q;

    // Completion is forwarded only to the owner; a stray mem_ready in idle
    // reaches neither port.
    assign p0_ready = (state_q == StGnt0) & mem_ready;
    assign p1_ready = (state_q == StGnt1) & mem_ready;

    assign p0_read_data = mem_read_data;
    assign p1_read_data = mem_read_data;

    assign p0_busy = req[0] & ~p0_ready;
    assign p1_busy = req[1] & ~p1_ready;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 32-bit SRAM controller port between two requesters: port 0 (MEM-stage data access) and port 1 (instruction fetch / secondary master).
- Sits between the pipeline and the SRAM controller. Grants one requester at a time and holds the controller command stable for the whole access.
- Routes the controller's completion pulse and read data back to the granted port.
- Drives per-port busy lines used as pipeline freeze.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p0_wr_en  in  1  port 0 write request; held until p0_ready.
- p0_rd_en  in  1  port 0 read request; held until p0_ready.
- p0_address  in  ADDR_W  port 0 byte address.
- p0_write_data  in  DATA_W  port 0 write data.
- p0_read_data  out  DATA_W  port 0 read data; valid only while p0_ready=1.
- p0_ready  out  1  port 0 completion pulse.
- p0_busy  out  1  port 0 freeze = request pending and not ready.
- p1_wr_en, p1_rd_en, p1_address, p1_write_data, p1_read_data, p1_ready, p1_busy: same as port 0, for port 1.
- mem_wr_en  out  1  write command to the SRAM controller.
- mem_rd_en  out  1  read command to the SRAM controller.
- mem_address  out  ADDR_W  command address to the SRAM controller.
- mem_write_data  out  DATA_W  command write data to the SRAM controller.
- mem_read_data  in  DATA_W  read data from the SRAM controller.
- mem_ready  in  1  one-cycle completion pulse from the SRAM controller.
- grant  out  2  one-hot status: bit0 = port 0 owns the SRAM, bit1 = port 1 owns it.

Behaviour:
- State machine IDLE, GNT0, GNT1.
  - Reset: state=IDLE; mem_wr_en=0, mem_rd_en=0, mem_address=0, mem_write_data=0, grant=0; last-served pointer=1.
- IDLE:
  - Samples requests. A port requests when wr_en|rd_en.
  - Winner's op, address and write data are registered into mem_*. State becomes GNT0 or GNT1 at the next edge.
  - Command latency: request seen in cycle n gives mem_*_en=1 in cycle n+1.
- Arbitration (base build): fixed priority, port 0 wins over port 1.
- Same port asserting both wr_en and rd_en: treated as a write; mem_rd_en stays 0.
- GNTx:
  - mem_* held constant regardless of requester input changes.
  - When mem_ready=1: px_ready=1 (combinational, same cycle) and px_read_data=mem_read_data.
  - At that edge: state goes to IDLE, mem_wr_en/mem_rd_en clear, last-served pointer = x.
- Non-granted port:
  - ready=0.
  - read_data is driven with mem_read_data but is don't-care.
- Guaranteed one-cycle IDLE gap between consecutive grants, so the controller sees enables low for at least one cycle.
- pX_busy = (pX_wr_en|pX_rd_en) & ~pX_ready. Combinational. Asserted through the whole wait, including while the port is not granted.
- Requester contract: drop or replace the request at the edge after seeing ready. A request still held in IDLE is treated as a new access.
- mem_ready while in IDLE: ignored; no port ready is asserted.
- rst mid-access: immediate return to the reset values. The SRAM controller shares rst, so no partial access survives. An in-flight port never sees ready.
- No timeout. A missing mem_ready stalls both ports indefinitely.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, the port that is not the last served wins. The pointer resets to 1, so port 0 wins the first tie. With a single requester, that requester wins.
- Undefined: fixed priority, port 0 wins. The pointer register is kept, but only updated and never read.

Decomposition:
- Package sram_arb_pkg holds:
  - the state encoding (IDLE, GNT0, GNT1);
  - port index constants PORT0=0, PORT1=1;
  - the grant one-hot constants.
- One natural sub-module: sram_arb_pick, a combinational picker. Inputs: two request bits and the last-served pointer. Output: winner index and valid. The macro selects fixed-priority or round-robin logic inside it.

Test Plan:
- Single read, port 0 only: p0_rd_en=1, p0_address=0x0000_0040; controller returns 0xDEAD_BEEF with mem_ready at cycle 6. Expect mem_rd_en=1 at cycle 1 with mem_address=0x40, p0_ready pulse with p0_read_data=0xDEAD_BEEF, p0_busy=1 until then, p1_ready=0 throughout.
- Simultaneous requests: p0 writes 0x1234_5678 to 0x100 while p1 reads 0x200. Base build: port 0 served first, IDLE gap, then port 1. With SRAM_ARB_RR_EN, a second tie after that goes to port 0, then port 1 alternates.
- Stability: during GNT1, toggle p1_address and p0_* every cycle. Expect mem_address constant at the latched value until mem_ready.
- Both wr_en and rd_en on port 1, address 0x300, data 0xA5A5_A5A5. Expect mem_wr_en=1, mem_rd_en=0, mem_write_data=0xA5A5_A5A5.
- Reset mid-access: assert rst two cycles into GNT0. Expect all mem_* and grant=0 asynchronously, state IDLE after release, no p0_ready pulse. After rst release with port 0 still requesting, expect a fresh grant at cycle n+1.
- Stray mem_ready in IDLE with no requests: expect p0_ready=p1_ready=0 and no state change.
